sa_cache_ctrl: RTL

Sequential N-way set-associative cache controller with write-back and write-allocate, and age-counter LRU replacement. Sits between a single-issue CPU load/store port and a line-wide backing memory port. Tag compare, way hit and data select are registered into a small FSM that handles victim write-back and line refill. Geometry, way count and data width are fully parametrised.

---
 rtl/sa_cache_pkg.sv | 23 ++
 rtl/sa_cache_lru.sv | 34 +++
 rtl/sa_cache_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sa_cache_pkg.sv
// Shared FSM state type and geometry helpers for the set-associative cache controller.
package sa_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL
  } state_t;

  function automatic int index_bits(input int cache_lines);
    return $clog2(cache_lines);
  endfunction

  function automatic int offset_bits(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int tag_bits(input int addr_width, input int cache_lines, input int line_bytes);
    return addr_width - $clog2(cache_lines) - $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/sa_cache_lru.sv
// Age-counter replacement for one set: picks a victim way and computes the ages after a hit.
module sa_cache_lru
  import sa_cache_pkg::*;
#(
  parameter int WAYS     = 4,
  parameter int AGE_BITS = 2
) (
  input  logic [WAYS-1:0][AGE_BITS-1:0] ages,
  input  logic [WAYS-1:0]               valid,
  input  logic [AGE_BITS-1:0]           hit_way,
  output logic [AGE_BITS-1:0]           victim,
  output logic [WAYS-1:0][AGE_BITS-1:0] next_ages
);

  // Oldest way is the fallback; the downward scan over invalid ways lets the lowest one win.
  always_comb begin
    victim = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (ages[w] == AGE_BITS'(WAYS - 1)) victim = AGE_BITS'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = AGE_BITS'(w);
    end
  end

  always_comb begin
    next_ages = ages;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_BITS'(w) == hit_way) next_ages[w] = '0;
      else if (ages[w] < ages[hit_way]) next_ages[w] = ages[w] + 1'b1;
    end
  end

endmodule

// File: rtl/sa_cache_ctrl.sv
// Write-back, write-allocate N-way set-associative cache controller with age-counter LRU.
// One request in flight; a miss writes back a dirty victim, refills, then replays the lookup.
module sa_cache_ctrl
  import sa_cache_pkg::*;
#(
  parameter int WAYS            = 4,
  parameter int CACHE_LINES     = 256,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic                         i_req_we,
  input  logic [ADDRESS_WIDTH-1:0]     i_req_addr,
  input  logic [DATA_WIDTH-1:0]        i_req_wdata,
  input  logic [DATA_WIDTH/8-1:0]      i_req_be,
  output logic                         o_rsp_valid,
  output logic [DATA_WIDTH-1:0]        o_rsp_rdata,
  output logic                         o_rsp_hit,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [ADDRESS_WIDTH-1:0]     o_mem_addr,
  output logic [LINE_SIZE_BYTES*8-1:0] o_mem_wdata,
  input  logic                         i_mem_ack,
  input  logic [LINE_SIZE_BYTES*8-1:0] i_mem_rdata
);

  localparam int INDEX_BITS     = index_bits(CACHE_LINES);
  localparam int OFFSET_BITS    = offset_bits(LINE_SIZE_BYTES);
  localparam int TAG_BITS       = tag_bits(ADDRESS_WIDTH, CACHE_LINES, LINE_SIZE_BYTES);
  localparam int LINE_SIZE_BITS = LINE_SIZE_BYTES * 8;
  localparam int AGE_BITS       = $clog2(WAYS);
  localparam int BYTES          = DATA_WIDTH / 8;
  localparam int BYTE_BITS      = $clog2(BYTES);

  logic [WAYS-1:0]                valid_q [CACHE_LINES];
  logic [WAYS-1:0]                dirty_q [CACHE_LINES];
  logic [WAYS-1:0][AGE_BITS-1:0]  age_q   [CACHE_LINES];
  logic [TAG_BITS-1:0]            tag_q   [CACHE_LINES][WAYS];
  logic [LINE_SIZE_BITS-1:0]      data_q  [CACHE_LINES][WAYS];

  state_t                    state_q, state_d;
  logic                      req_we_q, first_try_q;
  logic [ADDRESS_WIDTH-1:0]  req_addr_q;
  logic [DATA_WIDTH-1:0]     req_wdata_q;
  logic [BYTES-1:0]          req_be_q;
  logic [AGE_BITS-1:0]       victim_q;

  logic                      rsp_valid_q, rsp_hit_q, mem_req_q, mem_we_q;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q;
  logic [ADDRESS_WIDTH-1:0]  mem_addr_q;
  logic [LINE_SIZE_BITS-1:0] mem_wdata_q;

  logic [INDEX_BITS-1:0]     req_index;
  logic [TAG_BITS-1:0]       req_tag;
  logic [OFFSET_BITS-1:0]    word_sel;
  logic                      hit, victim_dirty, mem_ack;
  logic [AGE_BITS-1:0]       hit_way, victim;
  logic [WAYS-1:0][AGE_BITS-1:0] next_ages;
  logic [DATA_WIDTH-1:0]     cur_word, merged_word;
  logic                      accept, do_hit, start_wb, start_rf, wb_done, rf_done;

  assign req_index = req_addr_q[OFFSET_BITS +: INDEX_BITS];
  assign req_tag   = req_addr_q[ADDRESS_WIDTH-1 -: TAG_BITS];
  assign word_sel  = req_addr_q[OFFSET_BITS-1:0] >> BYTE_BITS;
  assign mem_ack   = i_mem_ack && mem_req_q;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_BITS'(w);
      end
    end
  end

  always_comb begin
    cur_word    = data_q[req_index][hit_way][word_sel*DATA_WIDTH +: DATA_WIDTH];
    merged_word = cur_word;
    for (int b = 0; b < BYTES; b++) begin
      if (req_be_q[b]) merged_word[b*8 +: 8] = req_wdata_q[b*8 +: 8];
    end
  end

  assign victim_dirty = valid_q[req_index][victim] && dirty_q[req_index][victim];

  sa_cache_lru #(
    .WAYS     (WAYS),
    .AGE_BITS (AGE_BITS)
  ) u_lru (
    .ages      (age_q[req_index]),
    .valid     (valid_q[req_index]),
    .hit_way   (hit_way),
    .victim    (victim),
    .next_ages (next_ages)
  );

  // REFILL issues its own request when entered from WRITEBACK, after the write-back req has dropped.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    do_hit   = 1'b0;
    start_wb = 1'b0;
    start_rf = 1'b0;
    wb_done  = 1'b0;
    rf_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          do_hit  = 1'b1;
          state_d = IDLE;
        end else if (victim_dirty) begin
          start_wb = 1'b1;
          state_d  = WRITEBACK;
        end else begin
          start_rf = 1'b1;
          state_d  = REFILL;
        end
      end
      WRITEBACK: begin
        if (mem_ack) begin
          wb_done = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem_ack) begin
          rf_done = 1'b1;
          state_d = LOOKUP;
        end else if (!mem_req_q) begin
          start_rf = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      first_try_q <= 1'b0;
      victim_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= do_hit;
      if (accept) begin
        req_we_q    <= i_req_we;
        req_addr_q  <= i_req_addr;
        req_wdata_q <= i_req_wdata;
        req_be_q    <= i_req_be;
        first_try_q <= 1'b1;
      end
      if (do_hit) begin
        rsp_hit_q   <= first_try_q;
        rsp_rdata_q <= req_we_q ? merged_word : cur_word;
      end
      if (state_q == LOOKUP && !hit) begin
        victim_q    <= victim;
        first_try_q <= 1'b0;
      end
      if (start_wb) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= {tag_q[req_index][victim], req_index, {OFFSET_BITS{1'b0}}};
        mem_wdata_q <= data_q[req_index][victim];
      end else if (start_rf) begin
        mem_req_q  <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= {req_tag, req_index, {OFFSET_BITS{1'b0}}};
      end else if (mem_ack) begin
        mem_req_q <= 1'b0;
      end
    end
  end

  // Way w starts at age w so every set holds a permutation of ages from reset onward.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int s = 0; s < CACHE_LINES; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_BITS'(w);
      end
    end else begin
      if (do_hit) begin
        age_q[req_index] <= next_ages;
        if (req_we_q) dirty_q[req_index][hit_way] <= 1'b1;
      end
      if (wb_done) dirty_q[req_index][victim_q] <= 1'b0;
      if (rf_done) begin
        valid_q[req_index][victim_q] <= 1'b1;
        dirty_q[req_index][victim_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && do_hit && req_we_q)
      data_q[req_index][hit_way][word_sel*DATA_WIDTH +: DATA_WIDTH] <= merged_word;
    if (i_rst_n && rf_done) begin
      data_q[req_index][victim_q] <= i_mem_rdata;
      tag_q[req_index][victim_q]  <= req_tag;
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_hit   = rsp_hit_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule
